// File: rtl/vector_addsub_stream.sv
// Element-wise FP32 add / sub / pass stage, LANES wide, with a fixed-latency
// adder per lane, an in-flight tracker and a credit-guarded output FIFO so
// that downstream may stall without any result being dropped.

// Fixed-latency FP32 adder (round-to-nearest-even, gradual underflow).
module fp32_add_core #(
  parameter int LAT = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tvalid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic [31:0] pipe_r [LAT];

  function automatic logic [31:0] fp32_add(input logic [31:0] fa, input logic [31:0] fb);
    logic [31:0] x, y, res;
    logic [7:0]  ex, ey, d;
    logic [23:0] mx, my;
    logic [26:0] ax, ay;
    logic [27:0] sum;
    logic [24:0] rm;
    logic [9:0]  e;
    logic        sticky, inc, a_nan, b_nan, a_inf, b_inf;
    a_nan = (&fa[30:23]) & (|fa[22:0]);
    b_nan = (&fb[30:23]) & (|fb[22:0]);
    a_inf = (&fa[30:23]) & ~(|fa[22:0]);
    b_inf = (&fb[30:23]) & ~(|fb[22:0]);
    res = 32'h0000_0000;
    if (a_nan || b_nan) begin
      res = 32'h7FC0_0000;
    end else if (a_inf && b_inf) begin
      res = (fa[31] == fb[31]) ? fa : 32'h7FC0_0000;
    end else if (a_inf) begin
      res = fa;
    end else if (b_inf) begin
      res = fb;
    end else begin
      // x always carries the larger magnitude so alignment only shifts y
      if (fa[30:0] >= fb[30:0]) begin
        x = fa; y = fb;
      end else begin
        x = fb; y = fa;
      end
      ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      mx = {|x[30:23], x[22:0]};
      my = {|y[30:23], y[22:0]};
      d  = ex - ey;
      ax = {mx, 3'b000};
      ay = {my, 3'b000};
      // Align y with guard/round bits and a sticky bit collecting the rest
      if (d >= 8'd27) begin
        ay = {26'd0, |my};
      end else begin
        sticky = |(ay & ((27'd1 << d) - 27'd1));
        ay     = ay >> d;
        ay[0]  = ay[0] | sticky;
      end
      e = {2'b00, ex};
      if (x[31] == y[31]) begin
        sum = {1'b0, ax} + {1'b0, ay};
        if (sum[27]) begin
          sum = {1'b0, sum[27:2], sum[1] | sum[0]};
          e   = e + 10'd1;
        end
      end else begin
        sum = {1'b0, ax} - {1'b0, ay};
        // Normalise left, but never below the denormal exponent
        for (int i = 0; i < 26; i++) begin
          if (!sum[26] && (e > 10'd1)) begin
            sum = sum << 1;
            e   = e - 10'd1;
          end else begin
            sum = sum;
          end
        end
      end
      if (sum[26:0] == 27'd0) begin
        // Exact zero: -0 only when both operands were -0
        res = {((x[31] == y[31]) ? x[31] : 1'b0), 31'd0};
      end else begin
        inc = sum[2] & (sum[1] | sum[0] | sum[3]);
        rm  = {1'b0, sum[26:3]} + {24'd0, inc};
        if (rm[24]) begin
          rm = rm >> 1;
          e  = e + 10'd1;
        end
        if (e >= 10'd255) begin
          res = {x[31], 8'hFF, 23'd0};
        end else begin
          res = {x[31], (rm[23] ? e[7:0] : 8'd0), rm[22:0]};
        end
      end
    end
    return res;
  endfunction

  // Result pipeline: stage 0 captures a new sum on tvalid, later stages shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe_r[i] <= 32'd0;
    end else begin
      if (tvalid) pipe_r[0] <= fp32_add(a, b);
      for (int i = 1; i < LAT; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign result = pipe_r[LAT-1];

endmodule

module vector_addsub_stream #(
  parameter int LANES      = 16,
  parameter int ADD_LAT    = 11,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES*32-1:0]   in_a,
  input  logic [LANES*32-1:0]   in_b,
  input  logic [1:0]            in_mode,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [LANES*32-1:0]   out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  ovf_err
);

  localparam int W  = LANES * 32;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(ADD_LAT + 1);
  localparam int TW = CW + IW + 1;

  logic [W-1:0]         prep_b_s, core_res_s;
  logic                 accept_s, tail_vld_s, push_s, pop_s;
  logic [ADD_LAT-1:0]   vld_sr_r, last_sr_r;
  logic [IW-1:0]        inflight_r, inflight_nxt_s;
  logic [CW-1:0]        count_r, count_nxt_s;
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r, rd_nxt_s;
  logic [W:0]           mem_r [FIFO_DEPTH];
  logic [W:0]           head_nxt_s;
  logic [TW-1:0]        total_s;
  logic [W-1:0]         out_data_r;
  logic                 out_last_r, out_valid_r, busy_r, ovf_err_r, rdy_en_r;

  assign accept_s   = in_valid & in_ready;
  assign tail_vld_s = vld_sr_r[ADD_LAT-1];
  assign pop_s      = out_valid_r & out_ready;
  // A write at full is only allowed when the head leaves in the same cycle
  assign push_s     = tail_vld_s & ((count_r != CW'(FIFO_DEPTH)) | pop_s);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [31:0] b_lane_s;

    // Operand B prep: sign flip for sub, -0.0 for pass (A + -0 == A exactly)
    always_comb begin
      case (in_mode)
        2'b01:   b_lane_s = {~in_b[32*g+31], in_b[32*g +: 31]};
        2'b10:   b_lane_s = 32'h8000_0000;
        default: b_lane_s = in_b[32*g +: 32];
      endcase
    end

    assign prep_b_s[32*g +: 32] = b_lane_s;

    fp32_add_core #(.LAT(ADD_LAT)) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .tvalid (accept_s),
      .a      (in_a[32*g +: 32]),
      .b      (b_lane_s),
      .result (core_res_s[32*g +: 32])
    );
  end

  // Next-state of the in-flight counter and FIFO occupancy
  always_comb begin
    case ({accept_s, tail_vld_s})
      2'b10:   inflight_nxt_s = inflight_r + IW'(1);
      2'b01:   inflight_nxt_s = inflight_r - IW'(1);
      default: inflight_nxt_s = inflight_r;
    endcase
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    rd_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    // Bypass the entry being written when it becomes the new head
    if (push_s && (wr_ptr_r == rd_nxt_s)) begin
      head_nxt_s = {last_sr_r[ADD_LAT-1], core_res_s};
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Credit check: room freed by this cycle's pop is usable immediately
  assign total_s  = TW'(count_r) - TW'(pop_s) + TW'(inflight_r);
  assign in_ready = rdy_en_r & (total_s < TW'(FIFO_DEPTH));

  // In-flight valid/last shift register mirroring the adder pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr_r  <= '0;
      last_sr_r <= '0;
    end else begin
      for (int i = ADD_LAT - 1; i > 0; i--) begin
        vld_sr_r[i]  <= vld_sr_r[i-1];
        last_sr_r[i] <= last_sr_r[i-1];
      end
      vld_sr_r[0]  <= accept_s;
      last_sr_r[0] <= in_last;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {last_sr_r[ADD_LAT-1], core_res_s};
    end
  end

  // Pointers, counters, registered head and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      inflight_r  <= '0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      ovf_err_r   <= 1'b0;
      rdy_en_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      rd_ptr_r    <= rd_nxt_s;
      count_r     <= count_nxt_s;
      inflight_r  <= inflight_nxt_s;
      out_valid_r <= (count_nxt_s != CW'(0));
      {out_last_r, out_data_r} <= head_nxt_s;
      busy_r      <= (count_nxt_s != CW'(0)) | (inflight_nxt_s != IW'(0));
      ovf_err_r   <= ovf_err_r | (tail_vld_s & (count_r == CW'(FIFO_DEPTH)) & ~pop_s);
      rdy_en_r    <= 1'b1;
    end
  end

  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign ovf_err   = ovf_err_r;

endmodule

// File: tb/tb_vector_addsub_stream.sv
// Bench for vector_addsub_stream: integer-valued FP32 operands so the
// reference sums are exact, expected beats kept in an ordered queue.
module tb_vector_addsub_stream;

  localparam int LANES      = 4;
  localparam int ADD_LAT    = 11;
  localparam int FIFO_DEPTH = 16;
  localparam int W          = LANES * 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_a, in_b, out_data;
  logic [1:0]   in_mode;
  logic         in_last, in_valid, in_ready, out_last, out_valid, out_ready, busy, ovf_err;

  vector_addsub_stream #(.LANES(LANES), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [W:0] exp_q[$];
  int         cyc = 0;
  int         pop_cnt = 0;
  int         mark_cnt = -1;
  int         first_pop_cyc = 0;
  int         last_pop_cyc = 0;
  int         rdy_mode = 1;
  logic [W:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Exact conversion of a small integer to FP32 bits
  function automatic logic [31:0] int2fp(input int v);
    int m, p;
    logic [31:0] r;
    if (v == 0) return 32'h0000_0000;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (m >= (1 << i)) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
    return r;
  endfunction

  task automatic make_rand(output logic [W-1:0] a, output logic [W-1:0] b,
                           output logic [1:0] mode, output logic [W-1:0] e);
    int ia, ib;
    mode = 2'($urandom_range(0, 3));
    for (int l = 0; l < LANES; l++) begin
      ia = int'($urandom_range(0, 2000)) - 1000;
      ib = int'($urandom_range(0, 2000)) - 1000;
      a[32*l +: 32] = int2fp(ia);
      b[32*l +: 32] = int2fp(ib);
      case (mode)
        2'b01:   e[32*l +: 32] = int2fp(ia - ib);
        2'b10:   e[32*l +: 32] = int2fp(ia);
        default: e[32*l +: 32] = int2fp(ia + ib);
      endcase
    end
  endtask

  // Output checker: every popped beat against the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", out_data, mon_e[W-1:0]);
        check("out_last", W'(out_last), W'(mon_e[W]));
      end
      if (pop_cnt == mark_cnt) first_pop_cyc = cyc;
      pop_cnt++;
      last_pop_cyc = cyc;
    end
  end

  // Downstream ready pattern: 0 = always ready, 1 = stalled, 2 = random
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Present one beat until accepted; starts and ends just after a rising edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] mode,
                      input logic last, input logic [W-1:0] e, output int waits);
    in_a = a; in_b = b; in_mode = mode; in_last = last; in_valid = 1'b1;
    waits = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({last, e});
        @(posedge clk);
        #1;
        return;
      end
      waits++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_errors++;
    $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", waits);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    in_valid = 1'b0;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check_int("drain_done", (exp_q.size() == 0) ? 1 : 0, 1);
    @(posedge clk);
    @(negedge clk);
    check("busy_idle", W'(busy), W'(1'b0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b, e;
    logic [1:0]   m;
    int           w, tot, acc, k, seen;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 2'b00; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(1'b0));
    check("rst_out_valid", W'(out_valid), W'(1'b0));
    check("rst_out_data", out_data, '0);
    check("rst_out_last", W'(out_last), W'(1'b0));
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_ovf_err", W'(ovf_err), W'(1'b0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_release", W'(in_ready), W'(1'b1));
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // 1.0 + 2.0 = 3.0 and its latency
    send({LANES{32'h3F80_0000}}, {LANES{32'h4000_0000}}, 2'b00, 1'b0, {LANES{32'h4040_0000}}, w);
    in_valid = 1'b0;
    seen = 0;
    for (k = 1; k < 60; k++) begin
      @(negedge clk);
      if (out_valid) begin seen = k; break; end
    end
    check_int("add_latency", seen, ADD_LAT + 1);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back alternating modes, including pass of -0 and a denormal
    send({LANES{32'h4040_0000}}, {LANES{32'h3F80_0000}}, 2'b01, 1'b0, {LANES{32'h4000_0000}}, w);
    send({LANES{32'h8000_0000}}, {LANES{32'h4120_0000}}, 2'b10, 1'b0, {LANES{32'h8000_0000}}, w);
    send({LANES{32'h4000_0000}}, {LANES{32'hBF00_0000}}, 2'b11, 1'b0, {LANES{32'h3FC0_0000}}, w);
    send({LANES{32'h0000_0001}}, {LANES{32'hC2C8_0000}}, 2'b10, 1'b1, {LANES{32'h0000_0001}}, w);
    send({LANES{32'h3F80_0000}}, {LANES{32'h3F80_0000}}, 2'b01, 1'b0, {LANES{32'h0000_0000}}, w);
    drain();

    // Throughput: 100 beats at one per cycle, last only on #100
    mark_cnt = pop_cnt;
    tot = 0;
    for (int i = 1; i <= 100; i++) begin
      make_rand(a, b, m, e);
      send(a, b, m, (i == 100), e, w);
      tot += w;
    end
    drain();
    check_int("thr_input_stalls", tot, 0);
    check_int("thr_output_count", pop_cnt - mark_cnt, 100);
    check_int("thr_output_span", last_pop_cyc - first_pop_cyc, 99);

    // Backpressure: exactly FIFO_DEPTH beats accepted while stalled
    rdy_mode = 1;
    idle(3);
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      make_rand(a, b, m, e);
      in_a = a; in_b = b; in_mode = m; in_last = (i[2:0] == 3'd7); in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({in_last, e});
        acc++;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_int("bp_accepted", acc, FIFO_DEPTH);
    check("bp_in_ready_low", W'(in_ready), W'(1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_mode = 0;
    drain();
    check("bp_ovf_err", W'(ovf_err), W'(1'b0));

    // Random valid/ready stalls
    rdy_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      make_rand(a, b, m, e);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      send(a, b, m, ($urandom_range(0, 7) == 0), e, w);
    end
    rdy_mode = 0;
    drain();
    check("rand_ovf_err", W'(ovf_err), W'(1'b0));

    // Reset with 3 beats queued and 5 in flight
    rdy_mode = 1;
    idle(3);
    for (int i = 0; i < 3; i++) begin
      make_rand(a, b, m, e);
      send(a, b, m, 1'b0, e, w);
    end
    idle(ADD_LAT + 3);
    for (int i = 0; i < 5; i++) begin
      make_rand(a, b, m, e);
      send(a, b, m, 1'b0, e, w);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", W'(out_valid), W'(1'b0));
    check("mid_rst_busy", W'(busy), W'(1'b0));
    check("mid_rst_in_ready", W'(in_ready), W'(1'b0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_mode = 0;
    seen = 0;
    for (int i = 0; i < ADD_LAT + 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_int("no_stale_beats", seen, 0);
    @(posedge clk);
    #1;
    mark_cnt = pop_cnt;
    send({LANES{32'h3F80_0000}}, {LANES{32'h4000_0000}}, 2'b00, 1'b1, {LANES{32'h4040_0000}}, w);
    drain();
    check_int("post_rst_beat_count", pop_cnt - mark_cnt, 1);
    check("final_ovf_err", W'(ovf_err), W'(1'b0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
